// File: rtl/adder_pkg.sv
// Shared sizing constants for the ripple-carry adder and its registered result.
package adder_pkg;
  localparam int ADDER_WIDTH        = 8;
  localparam int ADDER_RESULT_WIDTH = ADDER_WIDTH + 1;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the single stage repeated along the carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/adder_8bit.sv
// Ripple-carry adder with combinational sum/carry/overflow and a registered
// copy of {Cout,S}. Only the registered copy sees clk and rst.
module adder_8bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic [WIDTH-1:0] S_q,
  output logic             Cout_q
);

  // Each stage owns its carry-in/carry-out, so the chain is a sequence of
  // distinct nets rather than bits of one vector feeding back on itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = Cin;
    end else begin : g_rest
      assign ci = g_stage[i-1].co;
    end
    full_adder u_fa (
      .a   (A[i]),
      .b   (B[i]),
      .cin (ci),
      .s   (S[i]),
      .cout(co)
    );
  end

  assign Cout = g_stage[WIDTH-1].co;
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign V    = g_stage[WIDTH-1].ci ^ g_stage[WIDTH-1].co;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_q    <= '0;
      Cout_q <= 1'b0;
    end else begin
      S_q    <= S;
      Cout_q <= Cout;
    end
  end

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: directed corners, random operands
// against an arithmetic model, exhaustive Cin=0 sweep and registered path.
module tb_adder_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] S;
  logic       Cout;
  logic       V;
  logic [7:0] S_q;
  logic       Cout_q;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  adder_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .S     (S),
    .Cout  (Cout),
    .V     (V),
    .S_q   (S_q),
    .Cout_q(Cout_q)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer arithmetic
  function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin);
    int t;
    t = int'(a) + int'(b) + int'(cin);
    return t[8:0];
  endfunction

  function automatic logic model_v(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin);
    int r;
    r = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return (r > 127) || (r < -128);
  endfunction

  task automatic check9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic cin);
    A   = a;
    B   = b;
    Cin = cin;
    #1;
  endtask

  task automatic comb_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic cin);
    apply(a, b, cin);
    check9({tag, "_sum"}, {Cout, S}, model_sum(a, b, cin));
    check1({tag, "_v"}, V, model_v(a, b, cin));
  endtask

  task automatic clocked_step(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] e;
    @(negedge clk);
    apply(a, b, cin);
    exp_q.push_back(model_sum(a, b, cin));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check9("reg_path", {Cout_q, S_q}, e);
  endtask

  initial begin
    bit stop;
    rst = 1'b0;
    A   = '0;
    B   = '0;
    Cin = 1'b0;
    #2 rst = 1'b1;
    #1;
    check9("reset_async_clear", {Cout_q, S_q}, 9'h000);

    // Directed corners with rst high: combinational path ignores reset
    apply(8'h00, 8'h00, 1'b0);
    check9("zero_sum", {Cout, S}, 9'h000);
    check1("zero_v", V, 1'b0);
    apply(8'hFF, 8'h01, 1'b0);
    check9("ff_plus_1_sum", {Cout, S}, 9'h100);
    check1("ff_plus_1_v", V, 1'b0);
    apply(8'hFF, 8'hFF, 1'b0);
    check9("ff_plus_ff_sum", {Cout, S}, 9'h1FE);
    apply(8'h7F, 8'h01, 1'b0);
    check9("7f_plus_1_sum", {Cout, S}, 9'h080);
    check1("7f_plus_1_v", V, 1'b1);
    apply(8'hFF, 8'h00, 1'b1);
    check9("ff_plus_cin_sum", {Cout, S}, 9'h100);
    apply(8'h80, 8'h80, 1'b0);
    check1("neg_overflow_v", V, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check9("reset_hold", {Cout_q, S_q}, 9'h000);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check9("release_no_edge", {Cout_q, S_q}, 9'h000);

    // First load after release
    clocked_step(8'h80, 8'h80, 1'b0);
    check9("first_load_0x80", {Cout_q, S_q}, 9'h100);

    // Reset pulse between edges
    #2 rst = 1'b1;
    #1;
    check9("midcycle_rst_clear", {Cout_q, S_q}, 9'h000);
    check9("midcycle_rst_comb", {Cout, S}, 9'h100);
    rst = 1'b0;
    #1;
    check9("post_pulse_hold", {Cout_q, S_q}, 9'h000);
    @(posedge clk);
    #1;
    check9("post_pulse_reload", {Cout_q, S_q}, 9'h100);

    // Randomized combinational and registered checks
    for (int i = 0; i < 300; i++) begin
      comb_check("rand_comb", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 100; i++) begin
      clocked_step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
    end

    // Exhaustive (A,B) sweep with Cin=0, stop at first mismatch
    stop = 1'b0;
    for (int a = 0; a < 256 && !stop; a++) begin
      for (int b = 0; b < 256; b++) begin
        A   = 8'(a);
        B   = 8'(b);
        Cin = 1'b0;
        #1;
        tests++;
        assert ({Cout, S} === 9'(a + b))
        else begin
          fails++;
          $error("FAIL exhaustive a=%0d b=%0d observed=%h expected=%h", a, b, {Cout, S},
                 9'(a + b));
          stop = 1'b1;
        end
        if (stop) break;
      end
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
